present_round_ctrl: RTL and testbench
=====================================

PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 4: cycles per round, i.e. the register depth of the masked S-box pipeline; legal range 1..8.
REQ-002 SHALL have parameter ROUNDS, default 31: number of PRESENT rounds; legal range 1..31.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin one encryption; sampled only in IDLE.
REQ-006 SHALL have port sel, output, 1 bit: select for the state and key mux-flip-flops; 1 = load external D1 (plaintext/key shares), 0 = take round feedback D0.
REQ-007 SHALL have port round_cnt, output, 5 bits: current PRESENT round counter, fed into the key schedule.
REQ-008 SHALL have port key_upd, output, 1 bit: one-cycle pulse that commits the key-schedule update.
REQ-009 SHALL have port last, output, 1 bit: high for the whole final round (round_cnt == ROUNDS).
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse; ciphertext shares are valid at the state register in that cycle.

Function
REQ-012 SHALL implement an FSM with states IDLE, LOAD, RUN, FINAL and DONE, plus a stage counter (0..SBOX_LAT-1) and round_cnt.
REQ-013 IDLE: when start=1 at a rising edge, SHALL go to LOAD; otherwise SHALL stay in IDLE.
REQ-014 LOAD: SHALL last exactly 1 cycle with sel=1; SHALL then go to RUN with stage=0 and round_cnt=1.
REQ-015 RUN: stage SHALL increment each cycle; when stage=SBOX_LAT-1, key_upd SHALL be 1 in that cycle and stage SHALL wrap to 0.
REQ-016 RUN round end: at stage wrap with round_cnt<ROUNDS, round_cnt SHALL increment; with round_cnt==ROUNDS, SHALL go to FINAL and round_cnt SHALL hold.
REQ-017 FINAL: SHALL last 1 cycle (final key whitening), key_upd=0; SHALL then go to DONE.
REQ-018 DONE: done=1 for exactly 1 cycle; SHALL then return to IDLE with round_cnt=0.
REQ-019 sel SHALL be 1 only in LOAD and 0 in all other states, so the datapath flip-flops take feedback whenever not loading.
REQ-020 start SHALL be ignored in every state except IDLE; no queuing of requests.
REQ-021 Latency: start sampled at edge k SHALL give done=1 in cycle k+3+ROUNDS*SBOX_LAT (k+127 for the defaults).
REQ-022 start held continuously high SHALL give back-to-back encryptions with exactly one IDLE cycle between DONE and the next LOAD.
REQ-023 All outputs SHALL be registered or decoded from state only, with no combinational path from start to any output.
REQ-024 With SBOX_LAT=1, key_upd SHALL be high in every RUN cycle.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, stage=0, round_cnt=0, sel=0, key_upd=0, last=0, busy=0, done=0, overriding start.
REQ-026 reset asserted in any state mid-encryption SHALL abort that encryption; done SHALL NOT be produced for it.
REQ-027 After reset deasserts, the first start SHALL be honoured exactly as in REQ-013.

Verification
REQ-028 Apply reset, then start pulse at edge 0 (defaults) -> sel=1 in cycle 1; key_upd pulses in cycles 5, 9, ..., 125; last high in cycles 122-125; done=1 only in cycle 127.
REQ-029 Sample round_cnt over one run (defaults) -> 1 for cycles 2-5, incrementing every 4 cycles, 31 for cycles 122-126, 0 after DONE.
REQ-030 Pulse start again during RUN -> no effect: exactly one done, no extra sel pulse.
REQ-031 Assert reset in cycle 60 (RUN, round_cnt=15) -> next cycle all outputs are 0 and no done follows; a new start then runs the full 127-cycle sequence.
REQ-032 Hold start=1 continuously -> done in cycles 127 and 255, with LOAD in cycles 1 and 129.
REQ-033 Use SBOX_LAT=1, ROUNDS=2 -> sel in cycle 1, key_upd in cycles 2 and 3, FINAL in cycle 4, done in cycle 5.

Source files
------------

// File: rtl/present_round_ctrl.sv
// Round sequencer for a masked PRESENT core: drives the datapath load select,
// round counter, key-schedule update strobe and completion handshake.
module present_round_ctrl #(
    parameter int unsigned SBOX_LAT = 4,
    parameter int unsigned ROUNDS   = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       sel,
    output logic [4:0] round_cnt,
    output logic       key_upd,
    output logic       last,
    output logic       busy,
    output logic       done
);

    localparam int unsigned STAGE_W = 3;
    localparam int unsigned ROUND_W = 5;
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(SBOX_LAT - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 sel_d, key_upd_d, last_d, busy_d, done_d;

    // State, counters and outputs all flop together so outputs track the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            round_q <= '0;
            sel     <= 1'b0;
            key_upd <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            round_q <= round_d;
            sel     <= sel_d;
            key_upd <= key_upd_d;
            last    <= last_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state and counters; outputs are pre-decoded from the next state.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        round_d = round_q;

        unique case (state_q)
            IDLE: begin
                round_d = '0;
                stage_d = '0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
                stage_d = '0;
                round_d = ROUND_W'(1);
            end
            RUN: begin
                if (stage_q == STAGE_LAST) begin
                    stage_d = '0;
                    if (round_q == ROUND_LAST) begin
                        state_d = FINAL;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                    end
                end else begin
                    stage_d = stage_q + STAGE_W'(1);
                end
            end
            FINAL: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                round_d = '0;
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
                round_d = '0;
            end
        endcase

        sel_d     = (state_d == LOAD);
        key_upd_d = (state_d == RUN) && (stage_d == STAGE_LAST);
        last_d    = (state_d == RUN) && (round_d == ROUND_LAST);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    assign round_cnt = round_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed bench for present_round_ctrl: default configuration plus a
// SBOX_LAT=1 / ROUNDS=2 instance, checked cycle by cycle.
module tb_present_round_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start2;

    logic       sel1, key_upd1, last1, busy1, done1;
    logic [4:0] round_cnt1;
    logic       sel2, key_upd2, last2, busy2, done2;
    logic [4:0] round_cnt2;

    int total;
    int bad;

    present_round_ctrl dut_def (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sel       (sel1),
        .round_cnt (round_cnt1),
        .key_upd   (key_upd1),
        .last      (last1),
        .busy      (busy1),
        .done      (done1)
    );

    present_round_ctrl #(.SBOX_LAT(1), .ROUNDS(2)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .sel       (sel2),
        .round_cnt (round_cnt2),
        .key_upd   (key_upd2),
        .last      (last2),
        .busy      (busy2),
        .done      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {sel, key_upd, last, busy, done, round_cnt}.
    function automatic logic [9:0] obs1();
        return {sel1, key_upd1, last1, busy1, done1, round_cnt1};
    endfunction

    function automatic logic [9:0] obs2();
        return {sel2, key_upd2, last2, busy2, done2, round_cnt2};
    endfunction

    // Expected outputs for the default configuration, r cycles after the start edge.
    function automatic logic [9:0] model_default(int r);
        logic       e_sel, e_ku, e_last, e_busy, e_done;
        int         rc;
        e_sel  = (r == 1);
        e_ku   = (r >= 5) && (r <= 125) && (((r - 5) % 4) == 0);
        e_last = (r >= 122) && (r <= 125);
        e_busy = (r >= 1) && (r <= 127);
        e_done = (r == 127);
        if (r >= 2 && r <= 125)        rc = (r - 2) / 4 + 1;
        else if (r == 126 || r == 127) rc = 31;
        else                           rc = 0;
        return {e_sel, e_ku, e_last, e_busy, e_done, 5'(rc)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        reset  = 1'b1;
        start  = 1'b1;
        start2 = 1'b1;
        tick();
        tick();
        got = obs1();
        total++;
        if (got !== 10'b0) begin
            bad++;
            $display("FAIL reset_def: got %b want %b", got, 10'b0);
        end
        got = obs2();
        total++;
        if (got !== 10'b0) begin
            bad++;
            $display("FAIL reset_small: got %b want %b", got, 10'b0);
        end
        reset  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        tick();
        got = obs1();
        total++;
        if (got !== 10'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want %b", got, 10'b0);
        end
    endtask

    task automatic test_single_run();
        logic [9:0] got, exp;
        start = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            tick();
            start = 1'b0;
            got = obs1();
            exp = model_default(c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL single_run cycle %0d: got %b want %b", c, got, exp);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [9:0] got, exp;
        start = 1'b1;
        for (int c = 1; c <= 135; c++) begin
            tick();
            got = obs1();
            exp = model_default(c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL start_ignored cycle %0d: got %b want %b", c, got, exp);
            end
            start = (c == 40) || (c == 100) || (c == 127);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [9:0] got, exp;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            start = 1'b0;
            got = obs1();
            exp = model_default(c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL abort_prefix cycle %0d: got %b want %b", c, got, exp);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got = obs1();
        total++;
        if (got !== 10'b0) begin
            bad++;
            $display("FAIL abort_reset: got %b want %b", got, 10'b0);
        end
        for (int c = 0; c < 140; c++) begin
            tick();
            got = obs1();
            total++;
            if (got !== 10'b0) begin
                bad++;
                $display("FAIL abort_quiet cycle %0d: got %b want %b", c, got, 10'b0);
            end
        end
        start = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            tick();
            start = 1'b0;
            got = obs1();
            exp = model_default(c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL restart_run cycle %0d: got %b want %b", c, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got, exp;
        int r;
        start = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            tick();
            r = ((c - 1) % 128) + 1;
            exp = (r == 128) ? 10'b0 : model_default(r);
            got = obs1();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", c, got, exp);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_small_config();
        logic [9:0] got;
        logic [9:0] exp_tab [1:7];
        exp_tab[1] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
        exp_tab[2] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};
        exp_tab[3] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2};
        exp_tab[4] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2};
        exp_tab[5] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2};
        exp_tab[6] = 10'b0;
        exp_tab[7] = 10'b0;
        start2 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start2 = 1'b0;
            got = obs2();
            total++;
            if (got !== exp_tab[c]) begin
                bad++;
                $display("FAIL small_cfg cycle %0d: got %b want %b", c, got, exp_tab[c]);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        test_reset();
        test_single_run();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_small_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
